// File: rtl/stack_mem_unit_if.sv
// stack_mem_unit_if: command/response bundle between the control FSM (master) and the stack memory unit (slave).
interface stack_mem_unit_if #(
  parameter int WIDTH    = 16,
  parameter int MS_DEPTH = 32,
  parameter int RS_DEPTH = 16
);
  localparam int MSPW = $clog2(MS_DEPTH) + 1;
  localparam int RSPW = $clog2(RS_DEPTH) + 1;
  logic             MSPop, MSPWrite, MSPRegReset;
  logic             RSPop, RSPWrite, RSPRegReset;
  logic             MemRead1, MemRead2, MemWrite2;
  logic [1:0]       MemDst1, MemDst2, MemData;
  logic [WIDTH-1:0] pc_in, res_in, imm_in, valb_in;
  logic [WIDTH-1:0] rdata1, rdata2;
  logic [MSPW-1:0]  msp;
  logic [RSPW-1:0]  rsp;
  logic             ms_err, rs_err;
  modport master (
    output MSPop, MSPWrite, MSPRegReset, RSPop, RSPWrite, RSPRegReset,
           MemRead1, MemRead2, MemWrite2, MemDst1, MemDst2, MemData,
           pc_in, res_in, imm_in, valb_in,
    input  rdata1, rdata2, msp, rsp, ms_err, rs_err
  );
  modport slave (
    input  MSPop, MSPWrite, MSPRegReset, RSPop, RSPWrite, RSPRegReset,
           MemRead1, MemRead2, MemWrite2, MemDst1, MemDst2, MemData,
           pc_in, res_in, imm_in, valb_in,
    output rdata1, rdata2, msp, rsp, ms_err, rs_err
  );
endinterface

// File: rtl/stack_mem_unit.sv
// stack_mem_unit: main/return stack storage with count pointers, two registered read ports,
// one muxed write port and sticky fault flags for overflow, underflow and out-of-range access.
module stack_mem_unit #(
  parameter int WIDTH    = 16,
  parameter int MS_DEPTH = 32,
  parameter int RS_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  stack_mem_unit_if.slave bus
);
  localparam int MAW = $clog2(MS_DEPTH);
  localparam int RAW = $clog2(RS_DEPTH);
  localparam logic [MAW:0] MS_ONE  = (MAW+1)'(1);
  localparam logic [MAW:0] MS_TWO  = (MAW+1)'(2);
  localparam logic [MAW:0] MS_FULL = (MAW+1)'(MS_DEPTH);
  localparam logic [RAW:0] RS_ONE  = (RAW+1)'(1);
  localparam logic [RAW:0] RS_FULL = (RAW+1)'(RS_DEPTH);

  logic [WIDTH-1:0] r_ms [MS_DEPTH];
  logic [WIDTH-1:0] r_rs [RS_DEPTH];
  logic [MAW:0]     r_msp;
  logic [RAW:0]     r_rsp;
  logic [WIDTH-1:0] r_rdata1, r_rdata2;
  logic             r_ms_err, r_rs_err;

  logic             w_ms_top_ok, w_ms_sec_ok, w_ms_full, w_rs_top_ok, w_rs_full;
  logic [MAW-1:0]   w_ms_top_idx, w_ms_sec_idx, w_ms_new_idx;
  logic [RAW-1:0]   w_rs_top_idx;
  logic [WIDTH-1:0] w_ms_top, w_ms_sec, w_rs_top, w_wdata;
  logic [WIDTH-1:0] w_rd1_data, w_rd2_data;
  logic             w_rd1_ms_flt, w_rd1_rs_flt, w_rd2_ms_flt, w_rd2_rs_flt;
  logic             w_wr_ms_top, w_wr_ms_new, w_wr_rs_top, w_wr_ms_flt, w_wr_rs_flt;
  logic             w_msp_flt, w_rsp_flt, w_ms_flt, w_rs_flt;
  logic [MAW:0]     w_msp_nxt;
  logic [RAW:0]     w_rsp_nxt;

  // All addressing uses the pre-update pointers; pointer moves land after the edge.
  assign w_ms_top_ok  = r_msp != '0;
  assign w_ms_sec_ok  = r_msp >= MS_TWO;
  assign w_ms_full    = r_msp == MS_FULL;
  assign w_rs_top_ok  = r_rsp != '0;
  assign w_rs_full    = r_rsp == RS_FULL;
  assign w_ms_top_idx = MAW'(r_msp - MS_ONE);
  assign w_ms_sec_idx = MAW'(r_msp - MS_TWO);
  assign w_ms_new_idx = r_msp[MAW-1:0];
  assign w_rs_top_idx = RAW'(r_rsp - RS_ONE);
  assign w_ms_top     = r_ms[w_ms_top_idx];
  assign w_ms_sec     = r_ms[w_ms_sec_idx];
  assign w_rs_top     = r_rs[w_rs_top_idx];

  assign w_rd1_data = bus.MemDst1 == 2'd0 ? (w_ms_top_ok ? w_ms_top : '0) :
                      bus.MemDst1 == 2'd1 ? (w_ms_sec_ok ? w_ms_sec : '0) :
                      bus.MemDst1 == 2'd2 ? (w_rs_top_ok ? w_rs_top : '0) : '0;
  assign w_rd2_data = bus.MemDst2 == 2'd0 ? (w_ms_top_ok ? w_ms_top : '0) :
                      bus.MemDst2 == 2'd1 ? (w_ms_sec_ok ? w_ms_sec : '0) :
                      bus.MemDst2 == 2'd2 ? (w_rs_top_ok ? w_rs_top : '0) : '0;
  assign w_rd1_ms_flt = bus.MemRead1 && ((bus.MemDst1 == 2'd0 && !w_ms_top_ok) ||
                                         (bus.MemDst1 == 2'd1 && !w_ms_sec_ok));
  assign w_rd1_rs_flt = bus.MemRead1 && bus.MemDst1 == 2'd2 && !w_rs_top_ok;
  assign w_rd2_ms_flt = bus.MemRead2 && ((bus.MemDst2 == 2'd0 && !w_ms_top_ok) ||
                                         (bus.MemDst2 == 2'd1 && !w_ms_sec_ok));
  assign w_rd2_rs_flt = bus.MemRead2 && bus.MemDst2 == 2'd2 && !w_rs_top_ok;

  assign w_wdata = bus.MemData == 2'd0 ? bus.pc_in  :
                   bus.MemData == 2'd1 ? bus.res_in :
                   bus.MemData == 2'd2 ? bus.imm_in : bus.valb_in;
  assign w_wr_ms_top = bus.MemWrite2 && bus.MemDst2 == 2'd0;
  assign w_wr_rs_top = bus.MemWrite2 && bus.MemDst2 == 2'd1;
  assign w_wr_ms_new = bus.MemWrite2 && bus.MemDst2 == 2'd2;
  assign w_wr_ms_flt = (w_wr_ms_top && !w_ms_top_ok) || (w_wr_ms_new && w_ms_full);
  assign w_wr_rs_flt = w_wr_rs_top && !w_rs_top_ok;

  assign w_msp_flt = bus.MSPWrite && (bus.MSPop ? !w_ms_top_ok : w_ms_full);
  assign w_rsp_flt = bus.RSPWrite && (bus.RSPop ? !w_rs_top_ok : w_rs_full);
  assign w_msp_nxt = !bus.MSPWrite || w_msp_flt ? r_msp :
                     bus.MSPop ? r_msp - MS_ONE : r_msp + MS_ONE;
  assign w_rsp_nxt = !bus.RSPWrite || w_rsp_flt ? r_rsp :
                     bus.RSPop ? r_rsp - RS_ONE : r_rsp + RS_ONE;
  assign w_ms_flt  = w_rd1_ms_flt || w_rd2_ms_flt || w_wr_ms_flt || w_msp_flt;
  assign w_rs_flt  = w_rd1_rs_flt || w_rd2_rs_flt || w_wr_rs_flt || w_rsp_flt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_msp    <= '0;
      r_rsp    <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_ms_err <= 1'b0;
      r_rs_err <= 1'b0;
    end else begin
      if (bus.MemRead1) r_rdata1 <= w_rd1_data;
      if (bus.MemRead2) r_rdata2 <= w_rd2_data;
      r_msp    <= bus.MSPRegReset ? '0 : w_msp_nxt;
      r_rsp    <= bus.RSPRegReset ? '0 : w_rsp_nxt;
      r_ms_err <= bus.MSPRegReset ? 1'b0 : r_ms_err || w_ms_flt;
      r_rs_err <= bus.RSPRegReset ? 1'b0 : r_rs_err || w_rs_flt;
    end
  end

  // Storage keeps its contents through reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (rst && w_wr_ms_top && w_ms_top_ok) r_ms[w_ms_top_idx] <= w_wdata;
    if (rst && w_wr_ms_new && !w_ms_full) r_ms[w_ms_new_idx] <= w_wdata;
    if (rst && w_wr_rs_top && w_rs_top_ok) r_rs[w_rs_top_idx] <= w_wdata;
  end

  assign bus.rdata1 = r_rdata1;
  assign bus.rdata2 = r_rdata2;
  assign bus.msp    = r_msp;
  assign bus.rsp    = r_rsp;
  assign bus.ms_err = r_ms_err;
  assign bus.rs_err = r_rs_err;
endmodule

// File: doc/stack_mem_unit.md
Name: stack_mem_unit

Overview:
- Responder for the multicycle control FSM's stack and memory command interface.
- Holds the main stack (MS) and return stack (RS) storage, plus their pointers MSP and RSP.
- Executes pointer push/pop, registered reads on two read ports and a selectable-source write on port 2.
- Flags stack overflow, underflow and out-of-range accesses back to the datapath.

Parameters:
WIDTH, 16, data word width
MS_DEPTH, 32, main stack entries (power of 2)
RS_DEPTH, 16, return stack entries (power of 2)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-low reset
MSPop  in  1  MS pointer direction: 1 = pop (decrement), 0 = push (increment)
MSPWrite  in  1  apply MS pointer update this cycle
MSPRegReset  in  1  clear MSP and ms_err
RSPop  in  1  RS pointer direction, same encoding as MSPop
RSPWrite  in  1  apply RS pointer update
RSPRegReset  in  1  clear RSP and rs_err
MemRead1  in  1  read request, port 1
MemDst1  in  2  port 1 location select
MemRead2  in  1  read request, port 2
MemWrite2  in  1  write request, port 2
MemDst2  in  2  port 2 location select (read and write)
MemData  in  2  write source: 00 pc_in, 01 res_in, 10 imm_in, 11 valb_in
pc_in, res_in, imm_in, valb_in  in  WIDTH each  write data sources
rdata1  out  WIDTH  port 1 read data
rdata2  out  WIDTH  port 2 read data
msp  out  log2(MS_DEPTH)+1  current MS entry count
rsp  out  log2(RS_DEPTH)+1  current RS entry count
ms_err  out  1  sticky MS fault
rs_err  out  1  sticky RS fault

Behaviour:
- Reset (rst=0 at a clock edge):
  - msp=0, rsp=0, rdata1=0, rdata2=0, ms_err=0, rs_err=0.
  - Storage contents are not cleared.
  - Reset overrides every other input in the same cycle, including mid-sequence.
- Pointers are entry counts; 0 = empty.
  - MS top is MS[msp-1]; MS second is MS[msp-2].
  - RS top is RS[rsp-1].
- Read location select, MemDst1 and MemDst2 (reads):
  - 00 MS top; 01 MS second; 10 RS top; 11 reserved, reads 0.
- Write location select, MemDst2 (writes):
  - 00 MS top (overwrite); 01 RS top (overwrite); 10 MS[msp] (slot above top); 11 reserved, no write.
- Reads:
  - Registered, one-cycle latency: rdataN updates on the edge where MemReadN=1.
  - rdataN holds its value while MemReadN=0.
- Write:
  - Performed on the edge where MemWrite2=1, using the MemData-selected source.
- Simultaneous events in one cycle:
  - Every access (read or write) uses the pre-update pointer value.
  - Pointer updates take effect after the edge.
  - A read of the location written in the same cycle returns the old data (read-before-write).
  - Port 2 asserting both MemRead2 and MemWrite2: both execute, with the read returning old data.
  - MS and RS updates are independent and may occur in the same cycle.
- Pointer update rules:
  - RegReset has priority over Write for its stack.
  - Push when full (msp=MS_DEPTH / rsp=RS_DEPTH): pointer unchanged, set err.
  - Pop when empty: pointer unchanged, set err.
- Out-of-range accesses:
  - Reading MS top at msp=0, MS second at msp<2, or RS top at rsp=0 sets the stack's err, returns 0 in rdata, and leaves storage untouched.
  - Writing MS top at msp=0, RS top at rsp=0, or MS[msp] at msp=MS_DEPTH sets err and suppresses the write.
- Error flags:
  - ms_err and rs_err are sticky; cleared only by rst or by their RegReset.
  - An err flag never blocks later legal operations.
- Implementation constraints:
  - No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then push: reset; MemWrite2=1, MemDst2=10, MemData=10, imm_in=0x00AA, with MSPWrite=1, MSPop=0 in the same cycle -> msp=1. Next cycle MemRead1=1, MemDst1=00 -> rdata1=0x00AA one cycle later.
- Binary-op pattern: push 0x0005 then 0x0003. Read MS top on port 1 and MS second on port 2 in one cycle -> rdata1=0x0003, rdata2=0x0005. Then pop (msp=1) and overwrite MS top from res_in=0x0008 -> MS top reads 0x0008, msp=1.
- Return stack: push pc_in=0x0042 to RS via RSPWrite=1, RSPop=0 and MemDst2=01 write at rsp=1 -> RS top reads 0x0042. Then RSPop=1 -> rsp=0, rs_err=0.
- Underflow/overflow:
  - Pop at msp=0 -> msp stays 0, ms_err=1.
  - Push RS_DEPTH+1 times -> rsp=RS_DEPTH, rs_err=1.
  - RSPRegReset -> rsp=0, rs_err=0.
- Read-before-write collision: MS top=0x1111; same cycle MemRead1 MS top and MemWrite2 MS top with valb_in=0x2222 -> rdata1=0x1111, next read returns 0x2222.
- Reset mid-sequence: rst=0 in a cycle with MemWrite2=1 and MSPWrite=1 -> msp=0, rdata1=rdata2=0, errs 0, pointer not incremented.
